ctrl_ticket_distributor: RTL and testbench

//  Parametrised successor of the single-channel control path: receives control tickets on one
//  RQ/VLD input and distributes them to OUTPUT_COUNT RQ/VLD outputs, each with its own FIFO.

---
 rtl/ctrl_ticket_distributor_if.sv | 24 ++
 rtl/ctrl_ticket_distributor.sv | 110 +++++++++++
 tb/tb_ctrl_ticket_distributor.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_ticket_distributor_if.sv
// rtl/ctrl_ticket_distributor_if.sv - ticket input and per-channel output bundle
interface ctrl_ticket_distributor_if #(
  parameter int CTRL_DATA_WIDTH = 8,
  parameter int OUTPUT_COUNT    = 4
);
  logic [CTRL_DATA_WIDTH-1:0]              CTRL_DATA_IN;
  logic                                    CTRL_DATA_IN_VLD;
  logic                                    CTRL_DATA_IN_RQ;
  logic [OUTPUT_COUNT-1:0]                 CTRL_CHAN_EN;
  logic [OUTPUT_COUNT*CTRL_DATA_WIDTH-1:0] CTRL_DATA_OUT;
  logic [OUTPUT_COUNT-1:0]                 CTRL_DATA_OUT_VLD;
  logic [OUTPUT_COUNT-1:0]                 CTRL_DATA_OUT_RQ;
  logic [OUTPUT_COUNT-1:0]                 CTRL_FIFO_FULL;

  modport slave (
    input  CTRL_DATA_IN, CTRL_DATA_IN_VLD, CTRL_CHAN_EN, CTRL_DATA_OUT_RQ,
    output CTRL_DATA_IN_RQ, CTRL_DATA_OUT, CTRL_DATA_OUT_VLD, CTRL_FIFO_FULL
  );

  modport master (
    output CTRL_DATA_IN, CTRL_DATA_IN_VLD, CTRL_CHAN_EN, CTRL_DATA_OUT_RQ,
    input  CTRL_DATA_IN_RQ, CTRL_DATA_OUT, CTRL_DATA_OUT_VLD, CTRL_FIFO_FULL
  );
endinterface

// File: rtl/ctrl_ticket_distributor.sv
// rtl/ctrl_ticket_distributor.sv - fans control tickets out to per-channel FIFOs
module ctrl_ticket_distributor #(
  parameter int CTRL_DATA_WIDTH = 8,
  parameter int OUTPUT_COUNT    = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int SPLIT_MODE      = 0
) (
  input  logic                      CLK,
  input  logic                      RESET,
  ctrl_ticket_distributor_if.slave  bus
);
  localparam int W  = CTRL_DATA_WIDTH;
  localparam int N  = OUTPUT_COUNT;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(OUTPUT_COUNT);

  logic [W-1:0]   mem [N][FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr [N];
  logic [AW-1:0]  rd_ptr [N];
  logic [AW:0]    count [N];
  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  sel;
  logic           found;
  int             idx;
  logic           in_ready;
  logic           in_rq;
  logic           accept;
  logic [N-1:0]   full;
  logic [N-1:0]   out_vld;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   wr_en;
  logic [N-1:0]   rd_en;

  // Strict round-robin: first enabled channel at or after rr_ptr, full or not
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!found && bus.CTRL_CHAN_EN[idx]) begin
        sel   = PW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < N; i++) begin
      full[i]              = (count[i] == (AW+1)'(FIFO_DEPTH));
      out_vld[i]           = (count[i] != '0);
      out_data[i*W +: W]   = mem[i][rd_ptr[i]];
      rd_en[i]             = bus.CTRL_DATA_OUT_RQ[i] && out_vld[i];
    end
  end

  // in_ready holds IN_RQ low while reset is applied and for the first cycle after
  always_comb begin
    if (SPLIT_MODE == 0)
      in_rq = in_ready && (|bus.CTRL_CHAN_EN) && !(|(bus.CTRL_CHAN_EN & full));
    else
      in_rq = in_ready && (|bus.CTRL_CHAN_EN) && !full[sel];
    accept = in_rq && bus.CTRL_DATA_IN_VLD;
    for (int i = 0; i < N; i++) begin
      if (SPLIT_MODE == 0)
        wr_en[i] = accept && bus.CTRL_CHAN_EN[i];
      else
        wr_en[i] = accept && (sel == PW'(i));
    end
  end

  assign bus.CTRL_DATA_IN_RQ   = in_rq;
  assign bus.CTRL_DATA_OUT     = out_data;
  assign bus.CTRL_DATA_OUT_VLD = out_vld;
  assign bus.CTRL_FIFO_FULL    = full;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      in_ready <= 1'b0;
      rr_ptr   <= '0;
      for (int i = 0; i < N; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      in_ready <= 1'b1;
      if (accept && (SPLIT_MODE != 0))
        rr_ptr <= (sel == PW'(N-1)) ? '0 : sel + 1'b1;
      for (int i = 0; i < N; i++) begin
        if (wr_en[i])
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (rd_en[i])
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (wr_en[i] && !rd_en[i])
          count[i] <= count[i] + 1'b1;
        else if (!wr_en[i] && rd_en[i])
          count[i] <= count[i] - 1'b1;
      end
    end
  end

  // Ticket storage needs no reset; occupancy is tracked by the pointers and counts
  always_ff @(posedge CLK) begin
    for (int i = 0; i < N; i++)
      if (wr_en[i])
        mem[i][wr_ptr[i]] <= bus.CTRL_DATA_IN;
  end
endmodule

// File: tb/tb_ctrl_ticket_distributor.sv
// tb/tb_ctrl_ticket_distributor.sv - scoreboard bench for broadcast and round-robin builds
module tb_ctrl_ticket_distributor;
  logic CLK;
  logic RESET;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] sbq [8][$];

  ctrl_ticket_distributor_if #(.CTRL_DATA_WIDTH(8), .OUTPUT_COUNT(4)) bb ();
  ctrl_ticket_distributor_if #(.CTRL_DATA_WIDTH(8), .OUTPUT_COUNT(4)) rb ();

  ctrl_ticket_distributor #(.CTRL_DATA_WIDTH(8), .OUTPUT_COUNT(4), .FIFO_DEPTH(4), .SPLIT_MODE(0))
    u_bc (.CLK(CLK), .RESET(RESET), .bus(bb));
  ctrl_ticket_distributor #(.CTRL_DATA_WIDTH(8), .OUTPUT_COUNT(4), .FIFO_DEPTH(4), .SPLIT_MODE(1))
    u_rr (.CLK(CLK), .RESET(RESET), .bus(rb));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(int q, logic [7:0] obs, string tag);
    logic [7:0] e;
    chk({tag, "_nonempty"}, 32'(sbq[q].size() != 0), 32'd1);
    if (sbq[q].size() != 0) begin
      e = sbq[q].pop_front();
      chk(tag, 32'(obs), 32'(e));
    end
  endtask

  // Consumer side: every head ticket taken must match the oldest expected one
  always @(negedge CLK) begin
    if (RESET === 1'b0) begin
      for (int c = 0; c < 4; c++) begin
        if (bb.CTRL_DATA_OUT_VLD[c] && bb.CTRL_DATA_OUT_RQ[c])
          pop_check(c, bb.CTRL_DATA_OUT[c*8 +: 8], $sformatf("bc_ch%0d", c));
        if (rb.CTRL_DATA_OUT_VLD[c] && rb.CTRL_DATA_OUT_RQ[c])
          pop_check(4 + c, rb.CTRL_DATA_OUT[c*8 +: 8], $sformatf("rr_ch%0d", c));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic in_rq(int d);
    return (d == 0) ? bb.CTRL_DATA_IN_RQ : rb.CTRL_DATA_IN_RQ;
  endfunction

  task automatic drive_in(int d, logic v, logic [7:0] data);
    if (d == 0) begin
      bb.CTRL_DATA_IN_VLD = v;
      bb.CTRL_DATA_IN     = data;
    end else begin
      rb.CTRL_DATA_IN_VLD = v;
      rb.CTRL_DATA_IN     = data;
    end
  endtask

  task automatic send(int d, logic [7:0] data, logic [3:0] mask);
    logic ok;
    ok = 1'b0;
    drive_in(d, 1'b1, data);
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge CLK);
      ok = in_rq(d);
    end
    chk($sformatf("accept_%0d_%0h", d, data), 32'(ok), 32'd1);
    if (ok)
      for (int c = 0; c < 4; c++)
        if (mask[c]) sbq[d*4 + c].push_back(data);
    @(posedge CLK);
    #1;
    drive_in(d, 1'b0, 8'h00);
  endtask

  task automatic drain();
    bb.CTRL_DATA_OUT_RQ = 4'hF;
    rb.CTRL_DATA_OUT_RQ = 4'hF;
    repeat (8) tick();
    chk("drain_bc_vld", 32'(bb.CTRL_DATA_OUT_VLD), 32'h0);
    chk("drain_rr_vld", 32'(rb.CTRL_DATA_OUT_VLD), 32'h0);
  endtask

  initial begin
    RESET = 1'b1;
    drive_in(0, 1'b0, 8'h00);
    drive_in(1, 1'b0, 8'h00);
    bb.CTRL_CHAN_EN = 4'hF;  bb.CTRL_DATA_OUT_RQ = 4'hF;
    rb.CTRL_CHAN_EN = 4'hF;  rb.CTRL_DATA_OUT_RQ = 4'hF;
    repeat (2) tick();
    chk("rst_bc_vld",  32'(bb.CTRL_DATA_OUT_VLD), 32'h0);
    chk("rst_bc_full", 32'(bb.CTRL_FIFO_FULL), 32'h0);
    chk("rst_bc_rq",   32'(bb.CTRL_DATA_IN_RQ), 32'h0);
    chk("rst_rr_vld",  32'(rb.CTRL_DATA_OUT_VLD), 32'h0);
    chk("rst_rr_rq",   32'(rb.CTRL_DATA_IN_RQ), 32'h0);
    RESET = 1'b0;
    tick();

    // 1: broadcast, one-cycle latency, input stays ready
    send(0, 8'h11, 4'hF);
    chk("t1_vld",  32'(bb.CTRL_DATA_OUT_VLD), 32'hF);
    chk("t1_data", 32'(bb.CTRL_DATA_OUT), 32'h11111111);
    chk("t1_rq",   32'(bb.CTRL_DATA_IN_RQ), 32'h1);
    send(0, 8'h22, 4'hF);
    chk("t1_data2", 32'(bb.CTRL_DATA_OUT), 32'h22222222);
    chk("t1_rq2",   32'(bb.CTRL_DATA_IN_RQ), 32'h1);
    tick();
    chk("t1_empty", 32'(bb.CTRL_DATA_OUT_VLD), 32'h0);

    // 2: broadcast back-pressure from one stalled channel
    bb.CTRL_DATA_OUT_RQ = 4'b1011;
    for (int i = 0; i < 4; i++) send(0, 8'h31 + 8'(i), 4'hF);
    chk("t2_full", 32'(bb.CTRL_FIFO_FULL), 32'b0100);
    chk("t2_rq0",  32'(bb.CTRL_DATA_IN_RQ), 32'h0);
    bb.CTRL_DATA_OUT_RQ = 4'hF;
    tick();
    bb.CTRL_DATA_OUT_RQ = 4'b1011;
    chk("t2_rq1",   32'(bb.CTRL_DATA_IN_RQ), 32'h1);
    chk("t2_full1", 32'(bb.CTRL_FIFO_FULL), 32'h0);
    drain();

    // 3: round-robin over a sparse enable mask
    rb.CTRL_CHAN_EN = 4'b1011;
    rb.CTRL_DATA_OUT_RQ = 4'h0;
    send(1, 8'hA0, 4'b0001);
    send(1, 8'hA1, 4'b0010);
    send(1, 8'hA2, 4'b1000);
    send(1, 8'hA3, 4'b0001);
    send(1, 8'hA4, 4'b0010);
    send(1, 8'hA5, 4'b1000);
    chk("t3_vld", 32'(rb.CTRL_DATA_OUT_VLD), 32'b1011);
    drain();

    // 4: round-robin does not skip a full channel
    rb.CTRL_CHAN_EN = 4'b0010;
    rb.CTRL_DATA_OUT_RQ = 4'b1101;
    for (int i = 0; i < 4; i++) send(1, 8'hB0 + 8'(i), 4'b0010);
    chk("t4_full", 32'(rb.CTRL_FIFO_FULL), 32'b0010);
    chk("t4_rq0",  32'(rb.CTRL_DATA_IN_RQ), 32'h0);
    rb.CTRL_CHAN_EN = 4'hF;
    send(1, 8'hB4, 4'b0100);
    send(1, 8'hB5, 4'b1000);
    send(1, 8'hB6, 4'b0001);
    tick();
    chk("t4_rq_blocked", 32'(rb.CTRL_DATA_IN_RQ), 32'h0);
    chk("t4_only_ch1",   32'(rb.CTRL_DATA_OUT_VLD), 32'b0010);
    rb.CTRL_DATA_OUT_RQ = 4'hF;
    tick();
    rb.CTRL_DATA_OUT_RQ = 4'b1101;
    chk("t4_rq1", 32'(rb.CTRL_DATA_IN_RQ), 32'h1);
    send(1, 8'hB7, 4'b0010);
    drain();

    // 5: simultaneous read and write across pointer wrap
    bb.CTRL_CHAN_EN = 4'b0001;
    bb.CTRL_DATA_OUT_RQ = 4'h0;
    send(0, 8'hC0, 4'b0001);
    send(0, 8'hC1, 4'b0001);
    bb.CTRL_DATA_OUT_RQ = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      send(0, 8'hC2 + 8'(i), 4'b0001);
      chk($sformatf("t5_vld_%0d", i),  32'(bb.CTRL_DATA_OUT_VLD), 32'b0001);
      chk($sformatf("t5_full_%0d", i), 32'(bb.CTRL_FIFO_FULL), 32'h0);
    end
    tick();
    chk("t5_one_left", 32'(bb.CTRL_DATA_OUT_VLD), 32'b0001);
    tick();
    chk("t5_empty", 32'(bb.CTRL_DATA_OUT_VLD), 32'h0);

    // 6: reset mid-stream discards queued tickets and the RR pointer
    bb.CTRL_CHAN_EN = 4'hF;  bb.CTRL_DATA_OUT_RQ = 4'h0;
    rb.CTRL_CHAN_EN = 4'hF;  rb.CTRL_DATA_OUT_RQ = 4'h0;
    for (int i = 0; i < 3; i++) send(0, 8'hD0 + 8'(i), 4'hF);
    send(1, 8'hD0, 4'b0100);
    send(1, 8'hD1, 4'b1000);
    send(1, 8'hD2, 4'b0001);
    RESET = 1'b1;
    #1;
    chk("t6_bc_vld", 32'(bb.CTRL_DATA_OUT_VLD), 32'h0);
    chk("t6_bc_rq",  32'(bb.CTRL_DATA_IN_RQ), 32'h0);
    chk("t6_rr_vld", 32'(rb.CTRL_DATA_OUT_VLD), 32'h0);
    chk("t6_rr_rq",  32'(rb.CTRL_DATA_IN_RQ), 32'h0);
    for (int i = 0; i < 8; i++) sbq[i].delete();
    tick();
    RESET = 1'b0;
    tick();
    send(0, 8'h5A, 4'hF);
    chk("t6_bc_after", 32'(bb.CTRL_DATA_OUT), 32'h5A5A5A5A);
    send(1, 8'h5A, 4'b0001);
    chk("t6_rr_after", 32'(rb.CTRL_DATA_OUT_VLD), 32'b0001);
    drain();

    chk("sb_empty", 32'(sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()
                      + sbq[4].size() + sbq[5].size() + sbq[6].size() + sbq[7].size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
